operand_select_sequencer: RTL

- Micro-step sequencer that drives the 9-bit operand-select bus of the three-way operand selector (Y0/Y1/Y2 from t0–t3, i0, i1, const).
- Drives one-hot write enables for the t0–t3 temporary registers.
- Holds a small writable micro-program and steps through it from a start address until a step marked LAST.
- Supports a stall input and a start/busy/done handshake to the CPU control unit.

---
 rtl/operand_select_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/operand_select_sequencer.sv
// operand_select_sequencer: steps a writable micro-program to drive the operand-select bus and temp write enables.
// Optional step-limit abort is enabled by defining OPSEQ_STEP_LIMIT_EN.
module operand_select_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int MAX_STEPS = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [12:0]   prog_data,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          hold,
  output logic [8:0]    SEL,
  output logic [3:0]    t_we,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [8:0]    sel_q, sel_d;
  logic [3:0]    twe_q, twe_d;
  logic [12:0]   mem [DEPTH];
  logic [12:0]   entry;
  assign entry = mem[pc_q];
  // Program memory has no reset so a loaded program survives RST.
  always_ff @(posedge CLK)
    if (prog_we && state_q != RUN) mem[prog_addr] <= prog_data;
`ifdef OPSEQ_STEP_LIMIT_EN
  localparam int CW = $clog2(MAX_STEPS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sel_d   = sel_q;
    twe_d   = 4'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
        end
      end
      RUN: if (!hold) begin
        sel_d   = entry[8:0];
        twe_d   = entry[11] ? 4'(1) << entry[10:9] : 4'b0;
        pc_d    = pc_q + 1'b1;
        state_d = entry[12] ? DONE : RUN;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
`ifdef OPSEQ_STEP_LIMIT_EN
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
    // Abort once MAX_STEPS steps have been presented without reaching LAST.
    if (state_q == RUN) begin
      if (cnt_q == CW'(MAX_STEPS)) begin
        state_d = IDLE;
        sel_d   = '0;
        twe_d   = 4'b0;
        err_d   = 1'b1;
      end else if (!hold) cnt_d = cnt_q + 1'b1;
    end
`endif
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sel_q   <= '0;
      twe_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      twe_q   <= twe_d;
    end
`ifdef OPSEQ_STEP_LIMIT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign SEL  = sel_q;
  assign t_we = twe_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule
